// File: rtl/keypad_scanner_n_if.sv
// Keypad scanner bus: keypad lines, key event outputs and the code handshake.
interface keypad_scanner_n_if #(
  parameter int NUM_DIGITS = 4
);
  logic [3:0]              row;
  logic                    value_ack;
  logic [3:0]              col;
  logic                    key_valid;
  logic [3:0]              key_code;
  logic [4*NUM_DIGITS-1:0] value;
  logic [3:0]              digit_count;
  logic                    value_ready;

  modport slave (
    input  row, value_ack,
    output col, key_valid, key_code, value, digit_count, value_ready
  );

  modport master (
    output row, value_ack,
    input  col, key_valid, key_code, value, digit_count, value_ready
  );
endinterface

// File: rtl/keypad_scanner_n.sv
// 4x4 active-low keypad scanner: column scan, whole-scan debounce, key map,
// N-digit entry buffer with backspace/clear and a ready/ack handshake.
module keypad_scanner_n #(
  parameter int NUM_DIGITS     = 4,
  parameter int SETTLE_CYCLES  = 16,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int HEX_MODE       = 0
) (
  input logic               clk,
  input logic               rst,
  keypad_scanner_n_if.slave bus
);
  localparam int             VW    = 4 * NUM_DIGITS;
  localparam int             SW    = $clog2(SETTLE_CYCLES);
  localparam logic [SW-1:0]  LAST  = SW'(SETTLE_CYCLES - 1);
  localparam logic [VW-1:0]  ALL_F = '1;
  localparam logic [VW-1:0]  TOP_F = ~(ALL_F >> 4);
  localparam logic [3:0]     FULL  = 4'(NUM_DIGITS);
  localparam logic [7:0]     DB    = 8'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {S_IDLE, S_PRESS, S_HELD, S_REL} state_t;

  logic          r_active;
  logic [SW-1:0] r_slot;
  logic [1:0]    r_c;
  logic [1:0]    r_hits;
  logic [3:0]    r_scan_code;
  state_t        r_state;
  logic [3:0]    r_cand;
  logic [7:0]    r_n;
  logic          r_key_valid;
  logic [3:0]    r_key_code;
  logic [VW-1:0] r_value;
  logic [3:0]    r_count;
  logic          r_ready;

  logic [3:0] w_act;
  logic [2:0] w_pop;
  logic [1:0] w_row;
  logic [1:0] w_base_hits;
  logic [3:0] w_sum;
  logic [1:0] w_hits;
  logic [3:0] w_code;
  logic       w_sample;
  logic       w_scan_done;
  logic       w_none;
  logic       w_key;
  logic       w_accept;
  logic       w_hex;
  logic       w_pulse;

  function automatic logic [3:0] keymap(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0: keymap = 4'h1;  4'h1: keymap = 4'h2;  4'h2: keymap = 4'h3;  4'h3: keymap = 4'hA;
      4'h4: keymap = 4'h4;  4'h5: keymap = 4'h5;  4'h6: keymap = 4'h6;  4'h7: keymap = 4'hB;
      4'h8: keymap = 4'h7;  4'h9: keymap = 4'h8;  4'hA: keymap = 4'h9;  4'hB: keymap = 4'hC;
      4'hC: keymap = 4'h0;  4'hD: keymap = 4'hF;  4'hE: keymap = 4'hE;  default: keymap = 4'hD;
    endcase
  endfunction

  // Idle-high columns until the scan starts, then one column low at a time.
  assign bus.col         = r_active ? ~(4'b1000 >> r_c) : 4'b1111;
  assign bus.key_valid   = r_key_valid;
  assign bus.key_code    = r_key_code;
  assign bus.value       = r_value;
  assign bus.digit_count = r_count;
  assign bus.value_ready = r_ready;

  // Fold the current row sample into the running scan result (hit count saturates at 2).
  always_comb begin
    w_act = ~bus.row;
    w_pop = 3'd0;
    w_row = 2'd0;
    for (int b = 0; b < 4; b++) begin
      if (w_act[b]) begin
        w_pop = w_pop + 3'd1;
        w_row = 2'(3 - b);
      end
    end
    w_sample    = r_active && (r_slot == LAST);
    w_scan_done = w_sample && (r_c == 2'd3);
    w_base_hits = (r_c == 2'd0) ? 2'd0 : r_hits;
    w_sum       = {2'b00, w_base_hits} + {1'b0, w_pop};
    w_hits      = (w_sum > 4'd1) ? 2'd2 : w_sum[1:0];
    if (w_base_hits == 2'd0 && w_pop == 3'd1)
      w_code = keymap(w_row, r_c);
    else
      w_code = (r_c == 2'd0) ? 4'hF : r_scan_code;
    w_none   = (w_hits == 2'd0);
    w_key    = (w_hits == 2'd1);
    w_accept = w_scan_done && w_key &&
               (((r_state == S_IDLE) && (DB == 8'd1)) ||
                ((r_state == S_PRESS) && (w_code == r_cand) && (r_n + 8'd1 == DB)));
    w_hex    = (w_code >= 4'hA) && (w_code <= 4'hD);
    w_pulse  = w_accept && ((HEX_MODE != 0) || !w_hex);
  end

  // Slot/column counters and the per-scan accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_active    <= 1'b0;
      r_slot      <= '0;
      r_c         <= 2'd0;
      r_hits      <= 2'd0;
      r_scan_code <= 4'hF;
    end else begin
      r_active <= 1'b1;
      if (r_active) begin
        if (w_sample) begin
          r_slot      <= '0;
          r_c         <= r_c + 2'd1;
          r_hits      <= w_hits;
          r_scan_code <= w_code;
        end else begin
          r_slot <= r_slot + SW'(1);
        end
      end
    end
  end

  // Debounce FSM, stepped once per completed scan; holding a key never repeats.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cand  <= 4'hF;
      r_n     <= 8'd0;
    end else if (w_scan_done) begin
      case (r_state)
        S_IDLE: if (w_key) begin
          r_cand <= w_code;
          r_n    <= 8'd1;
          r_state <= (DB == 8'd1) ? S_HELD : S_PRESS;
        end
        S_PRESS: if (w_key && (w_code == r_cand)) begin
          if (r_n + 8'd1 == DB) r_state <= S_HELD;
          else                  r_n     <= r_n + 8'd1;
        end else begin
          r_state <= S_IDLE;
        end
        S_HELD: if (w_none) begin
          r_n     <= 8'd1;
          r_state <= (DB == 8'd1) ? S_IDLE : S_REL;
        end
        default: if (w_none) begin
          if (r_n + 8'd1 == DB) r_state <= S_IDLE;
          else                  r_n     <= r_n + 8'd1;
        end else begin
          r_state <= S_HELD;
        end
      endcase
    end
  end

  // Key event and entry buffer; an ack beats a simultaneous key action.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_key_valid <= 1'b0;
      r_key_code  <= 4'hF;
      r_value     <= ALL_F;
      r_count     <= 4'd0;
      r_ready     <= 1'b0;
    end else begin
      r_key_valid <= w_pulse;
      if (w_pulse) r_key_code <= w_code;
      if (bus.value_ack && (r_ready || w_pulse)) begin
        r_value <= ALL_F;
        r_count <= 4'd0;
        r_ready <= 1'b0;
      end else if (w_pulse && !r_ready) begin
        case (w_code)
          4'hF: begin
            r_value <= ALL_F;
            r_count <= 4'd0;
          end
          4'hE: if (r_count != 4'd0) begin
            r_value <= (r_value >> 4) | TOP_F;
            r_count <= r_count - 4'd1;
          end
          default: begin
            r_value <= (r_value << 4) | VW'(w_code);
            r_count <= r_count + 4'd1;
            r_ready <= (r_count + 4'd1 == FULL);
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_keypad_scanner_n.sv
// Directed bench for keypad_scanner_n with a behavioural 4x4 keypad matrix.
module tb_keypad_scanner_n;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] keys = 16'h0;
  int          checks = 0;
  int          errors = 0;
  int          pulses = 0;
  logic [3:0]  last_code = 4'hF;

  always #5 clk = ~clk;

  keypad_scanner_n_if #(.NUM_DIGITS(4)) kif ();

  keypad_scanner_n #(
    .NUM_DIGITS(4), .SETTLE_CYCLES(4), .DEBOUNCE_SCANS(2), .HEX_MODE(0)
  ) dut (
    .clk(clk), .rst(rst), .bus(kif.slave)
  );

  // Key index = row*4 + column; a pressed key pulls its row low while its column is driven.
  always_comb begin
    kif.row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !kif.col[3-c]) kif.row[3-r] = 1'b0;
  end

  always @(negedge clk) begin
    if (kif.key_valid === 1'b1) begin
      pulses    = pulses + 1;
      last_code = kif.key_code;
    end
  end

  task automatic wait_scan_start();
    logic [3:0] prev;
    int n;
    prev = kif.col;
    n = 0;
    forever begin
      @(negedge clk);
      if (kif.col == 4'b0111 && prev != 4'b0111) break;
      prev = kif.col;
      n++;
      if (n > 200) begin
        checks++; errors++;
        $display("FAIL scan_start_timeout col=%b", kif.col);
        break;
      end
    end
  endtask

  task automatic press(input int idx, input int scans);
    wait_scan_start();
    keys = 16'(1) << idx;
    repeat (scans * 16) @(negedge clk);
    keys = 16'h0;
    repeat (48) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [3:0] exp_col;
    rst = 1'b1; keys = 16'h0; kif.value_ack = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (kif.col !== 4'b1111) begin errors++; $display("FAIL reset_col got %b want 1111", kif.col); end
    checks++; if (kif.key_valid !== 1'b0) begin errors++; $display("FAIL reset_kv got %b want 0", kif.key_valid); end
    checks++; if (kif.key_code !== 4'hF) begin errors++; $display("FAIL reset_code got %h want f", kif.key_code); end
    checks++; if (kif.value !== 16'hFFFF) begin errors++; $display("FAIL reset_value got %h want ffff", kif.value); end
    checks++; if (kif.digit_count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", kif.digit_count); end
    checks++; if (kif.value_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", kif.value_ready); end
    rst = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      exp_col = ~(4'b1000 >> ((i - 1) / 4));
      checks++;
      if (kif.col !== exp_col) begin errors++; $display("FAIL scan_col cycle %0d got %b want %b", i, kif.col, exp_col); end
    end
    checks++; if (kif.key_valid !== 1'b0 || kif.value !== 16'hFFFF) begin
      errors++; $display("FAIL idle_outputs kv=%b value=%h want 0/ffff", kif.key_valid, kif.value);
    end
  endtask

  task automatic test_single_press();
    int p0;
    p0 = pulses;
    wait_scan_start();
    keys = 16'(1) << 5;
    repeat (31) @(negedge clk);
    checks++; if (kif.key_valid !== 1'b0) begin errors++; $display("FAIL early_pulse got %b want 0", kif.key_valid); end
    @(negedge clk);
    checks++; if (kif.key_valid !== 1'b1 || kif.key_code !== 4'h5) begin
      errors++; $display("FAIL accept_timing kv=%b code=%h want 1/5", kif.key_valid, kif.key_code);
    end
    repeat (16) @(negedge clk);
    keys = 16'h0;
    repeat (48) @(negedge clk);
    checks++; if (pulses - p0 !== 1) begin errors++; $display("FAIL single_pulse_count got %0d want 1", pulses - p0); end
    checks++; if (kif.value !== 16'hFFF5 || kif.digit_count !== 4'd1) begin
      errors++; $display("FAIL first_digit value=%h count=%0d want fff5/1", kif.value, kif.digit_count);
    end
    press(5, 3);
    checks++; if (pulses - p0 !== 2 || kif.value !== 16'hFF55) begin
      errors++; $display("FAIL second_press pulses=%0d value=%h want 2/ff55", pulses - p0, kif.value);
    end
    press(13, 3);
    checks++; if (kif.value !== 16'hFFFF || kif.digit_count !== 4'd0) begin
      errors++; $display("FAIL clear_after_55 value=%h count=%0d want ffff/0", kif.value, kif.digit_count);
    end
  endtask

  task automatic test_full_ack();
    int p0;
    press(0, 3); press(1, 3); press(2, 3); press(4, 3);
    checks++; if (kif.value !== 16'h1234 || kif.digit_count !== 4'd4 || kif.value_ready !== 1'b1) begin
      errors++; $display("FAIL full_code value=%h count=%0d ready=%b want 1234/4/1", kif.value, kif.digit_count, kif.value_ready);
    end
    p0 = pulses;
    press(8, 3);
    checks++; if (pulses - p0 !== 1 || last_code !== 4'h7) begin
      errors++; $display("FAIL press_while_ready pulses=%0d code=%h want 1/7", pulses - p0, last_code);
    end
    checks++; if (kif.value !== 16'h1234 || kif.value_ready !== 1'b1) begin
      errors++; $display("FAIL buffer_frozen value=%h ready=%b want 1234/1", kif.value, kif.value_ready);
    end
    kif.value_ack = 1'b1;
    @(negedge clk);
    kif.value_ack = 1'b0;
    checks++; if (kif.value !== 16'hFFFF || kif.digit_count !== 4'd0 || kif.value_ready !== 1'b0) begin
      errors++; $display("FAIL ack_clear value=%h count=%0d ready=%b want ffff/0/0", kif.value, kif.digit_count, kif.value_ready);
    end
  endtask

  task automatic test_edit();
    int p0;
    press(10, 3); press(9, 3);
    checks++; if (kif.value !== 16'hFF98 || kif.digit_count !== 4'd2) begin
      errors++; $display("FAIL enter_98 value=%h count=%0d want ff98/2", kif.value, kif.digit_count);
    end
    press(14, 3);
    checks++; if (kif.value !== 16'hFFF9 || kif.digit_count !== 4'd1) begin
      errors++; $display("FAIL backspace value=%h count=%0d want fff9/1", kif.value, kif.digit_count);
    end
    press(13, 3);
    checks++; if (kif.value !== 16'hFFFF || kif.digit_count !== 4'd0) begin
      errors++; $display("FAIL clear value=%h count=%0d want ffff/0", kif.value, kif.digit_count);
    end
    p0 = pulses;
    press(14, 3);
    checks++; if (kif.value !== 16'hFFFF || kif.digit_count !== 4'd0 || pulses - p0 !== 1 || last_code !== 4'hE) begin
      errors++; $display("FAIL backspace_empty value=%h count=%0d pulses=%0d code=%h want ffff/0/1/e",
                         kif.value, kif.digit_count, pulses - p0, last_code);
    end
  endtask

  task automatic test_reject();
    int p0;
    p0 = pulses;
    wait_scan_start();
    keys = 16'(1) << 5;
    repeat (16) @(negedge clk);
    keys = 16'h0;
    repeat (64) @(negedge clk);
    checks++; if (pulses !== p0) begin errors++; $display("FAIL bounce_pulse got %0d want 0", pulses - p0); end
    wait_scan_start();
    keys = (16'(1) << 0) | (16'(1) << 4);
    repeat (48) @(negedge clk);
    keys = 16'h0;
    repeat (48) @(negedge clk);
    checks++; if (pulses !== p0 || kif.value !== 16'hFFFF) begin
      errors++; $display("FAIL multi_pulse pulses=%0d value=%h want 0/ffff", pulses - p0, kif.value);
    end
    press(0, 3);
    kif.value_ack = 1'b1;
    @(negedge clk);
    kif.value_ack = 1'b0;
    @(negedge clk);
    checks++; if (kif.value !== 16'hFFF1 || kif.digit_count !== 4'd1) begin
      errors++; $display("FAIL ack_not_ready value=%h count=%0d want fff1/1", kif.value, kif.digit_count);
    end
    p0 = pulses;
    press(3, 3);
    checks++; if (pulses !== p0 || kif.value !== 16'hFFF1) begin
      errors++; $display("FAIL hex_key pulses=%0d value=%h want 0/fff1", pulses - p0, kif.value);
    end
    press(13, 3);
  endtask

  task automatic test_reset_held();
    int p0;
    wait_scan_start();
    keys = 16'(1) << 2;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    p0 = pulses;
    repeat (32) @(negedge clk);
    checks++; if (pulses !== p0 || kif.key_valid !== 1'b0) begin
      errors++; $display("FAIL reset_held_early pulses=%0d kv=%b want 0/0", pulses - p0, kif.key_valid);
    end
    @(negedge clk);
    checks++; if (kif.key_valid !== 1'b1 || kif.key_code !== 4'h3) begin
      errors++; $display("FAIL reset_held_accept kv=%b code=%h want 1/3", kif.key_valid, kif.key_code);
    end
    keys = 16'h0;
    repeat (48) @(negedge clk);
    press(13, 3);
  endtask

  task automatic test_ack_on_accept();
    press(0, 3); press(1, 3); press(2, 3);
    checks++; if (kif.value !== 16'hF123 || kif.digit_count !== 4'd3) begin
      errors++; $display("FAIL three_digits value=%h count=%0d want f123/3", kif.value, kif.digit_count);
    end
    wait_scan_start();
    keys = 16'(1) << 4;
    repeat (31) @(negedge clk);
    kif.value_ack = 1'b1;
    @(negedge clk);
    kif.value_ack = 1'b0;
    checks++; if (kif.key_valid !== 1'b1 || kif.key_code !== 4'h4) begin
      errors++; $display("FAIL ack_accept_pulse kv=%b code=%h want 1/4", kif.key_valid, kif.key_code);
    end
    checks++; if (kif.value !== 16'hFFFF || kif.digit_count !== 4'd0 || kif.value_ready !== 1'b0) begin
      errors++; $display("FAIL ack_wins value=%h count=%0d ready=%b want ffff/0/0", kif.value, kif.digit_count, kif.value_ready);
    end
    repeat (16) @(negedge clk);
    keys = 16'h0;
    repeat (48) @(negedge clk);
  endtask

  initial begin
    kif.value_ack = 1'b0;
    test_reset();
    test_single_press();
    test_full_ack();
    test_edit();
    test_reject();
    test_reset_held();
    test_ack_on_accept();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
